// File: rtl/input_capture_block.sv
// Input capture block: synchronizes timer_in, detects edges and latches the
// free-running 8-bit counter into per-channel capture registers with sticky
// flags, overrun bits and maskable interrupts. With pw_mode set, channels 0/1
// are paired by a small FSM to measure high-pulse width.
// Optional build macro: CAPTURE_FILTER_EN adds a FILTER_LEN-clock glitch
// filter between the synchronizer and the edge detector.

// One capture channel: capture register, sticky flag and overrun.
module capture_channel (
  input  logic       clk,
  input  logic       rst,
  input  logic       hit,
  input  logic       clr,
  input  logic [7:0] counter_value,
  output logic [7:0] cap_value,
  output logic       flag,
  output logic       overrun
);

  // A capture beats a same-cycle clear; a capture on a still-set flag marks overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_value <= '0;
      flag      <= 1'b0;
      overrun   <= 1'b0;
    end else if (hit) begin
      cap_value <= counter_value;
      flag      <= 1'b1;
      if (flag && !clr) overrun <= 1'b1;
      else if (clr)     overrun <= 1'b0;
    end else if (clr) begin
      flag    <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

module input_capture_block #(
  parameter int NUM_CAP     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    timer_in,
  input  logic [7:0]              counter_value,
  input  logic [NUM_CAP-1:0][1:0] edge_sel,
  input  logic [NUM_CAP-1:0]      intr_en,
  input  logic [NUM_CAP-1:0]      flag_clr,
  input  logic                    pw_mode,
  output logic [NUM_CAP-1:0][7:0] cap_value,
  output logic [7:0]              pulse_width,
  output logic [NUM_CAP-1:0]      flag,
  output logic [NUM_CAP-1:0]      overrun,
  output logic [NUM_CAP-1:0]      intr
);

  typedef enum logic {PW_IDLE, PW_HIGH} pw_state_t;

  // Elaboration-time parameter sanity checks.
  if (NUM_CAP < 2) begin : g_chk_num_cap
    $error("NUM_CAP must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (FILTER_LEN < 1) begin : g_chk_filter
    $error("FILTER_LEN must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q;
  logic                   lvl;
  logic                   prev_q;
  logic                   rise, fall;
  pw_state_t              pw_state, pw_state_nx;
  logic                   pw_start, pw_stop;
  logic [NUM_CAP-1:0]     hit;

  // Metastability synchronizer on the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_ff <= '0;
    else     sync_ff <= {sync_ff[SYNC_STAGES-2:0], timer_in};
  end

  assign sync_q = sync_ff[SYNC_STAGES-1];

`ifdef CAPTURE_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] filt_cnt;
  logic          filt_q;

  // Filtered level follows sync_q only after FILTER_LEN stable clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_cnt <= '0;
      filt_q   <= 1'b0;
    end else if (sync_q == filt_q) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      filt_q   <= sync_q;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q;
`endif

  // Delayed copy of the level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= lvl;
  end

  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;

  // Pulse-width FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pw_state <= PW_IDLE;
    else     pw_state <= pw_state_nx;
  end

  // Pulse-width FSM: rise starts a measurement, fall ends it; leaving pw_mode aborts.
  always_comb begin
    pw_state_nx = pw_state;
    pw_start    = 1'b0;
    pw_stop     = 1'b0;
    if (!pw_mode) begin
      pw_state_nx = PW_IDLE;
    end else begin
      case (pw_state)
        PW_IDLE: if (rise) begin
          pw_start    = 1'b1;
          pw_state_nx = PW_HIGH;
        end
        PW_HIGH: if (fall) begin
          pw_stop     = 1'b1;
          pw_state_nx = PW_IDLE;
        end
        default: pw_state_nx = PW_IDLE;
      endcase
    end
  end

  // Per-channel capture events; channels 0/1 are owned by the FSM in pw_mode.
  always_comb begin
    for (int i = 0; i < NUM_CAP; i++)
      hit[i] = (edge_sel[i][0] & rise) | (edge_sel[i][1] & fall);
    if (pw_mode) begin
      hit[0] = pw_start;
      hit[1] = pw_stop;
    end
  end

  for (genvar i = 0; i < NUM_CAP; i++) begin : g_ch
    capture_channel u_ch (
      .clk          (clk),
      .rst          (rst),
      .hit          (hit[i]),
      .clr          (flag_clr[i]),
      .counter_value(counter_value),
      .cap_value    (cap_value[i]),
      .flag         (flag[i]),
      .overrun      (overrun[i])
    );
  end

  // Width is the 8-bit modular distance from the rise capture to the fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pulse_width <= '0;
    else if (pw_stop) pulse_width <= counter_value - cap_value[0];
  end

  assign intr = intr_en & flag;

endmodule

// File: tb/tb_input_capture_block.sv
// Self-checking bench for input_capture_block: directed scenarios plus a
// randomized run compared every cycle against a history-based reference model.
module tb_input_capture_block;

  localparam int NUM_CAP     = 3;
  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 3;
`ifdef CAPTURE_FILTER_EN
  localparam int LAT = SYNC_STAGES + 1 + FILTER_LEN;
`else
  localparam int LAT = SYNC_STAGES + 1;
`endif
  localparam int MAXN = 8192;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    timer_in = 1'b0;
  logic [7:0]              counter_value = '0;
  logic [NUM_CAP-1:0][1:0] edge_sel = '0;
  logic [NUM_CAP-1:0]      intr_en = '0;
  logic [NUM_CAP-1:0]      flag_clr = '0;
  logic                    pw_mode = 1'b0;
  logic [NUM_CAP-1:0][7:0] cap_value;
  logic [7:0]              pulse_width;
  logic [NUM_CAP-1:0]      flag, overrun, intr;

  int vectors = 0;
  int miscompares = 0;

  input_capture_block #(.NUM_CAP(NUM_CAP), .SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) dut (
    .clk(clk), .rst(rst), .timer_in(timer_in), .counter_value(counter_value),
    .edge_sel(edge_sel), .intr_en(intr_en), .flag_clr(flag_clr), .pw_mode(pw_mode),
    .cap_value(cap_value), .pulse_width(pulse_width), .flag(flag),
    .overrun(overrun), .intr(intr)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // t_hist[k] = timer_in sampled at rising edge k since time zero.
  bit         t_hist [MAXN];
  bit         f_hist [MAXN];
  int         n = 0;
  int         rbase = 0;
  logic [7:0] m_cap [NUM_CAP] = '{default: 8'h00};
  logic [7:0] m_pw = '0;
  logic [NUM_CAP-1:0] m_flag = '0, m_ovr = '0;
  bit         m_high = 1'b0;
  bit         md_rise, md_fall, md_all;
  bit [NUM_CAP-1:0] md_ev;

  function automatic bit tv(int k);
    return (k <= rbase) ? 1'b0 : t_hist[k];
  endfunction
  // Synchronized input level after edge m.
  function automatic bit rawlv(int m);
    return tv(m - SYNC_STAGES + 1);
  endfunction
  // Level the edge detector sees after edge m.
  function automatic bit lv(int m);
`ifdef CAPTURE_FILTER_EN
    return (m <= rbase) ? 1'b0 : f_hist[m];
`else
    return rawlv(m);
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rbase = n;
      m_flag = '0; m_ovr = '0; m_pw = '0; m_high = 1'b0;
      for (int i = 0; i < NUM_CAP; i++) m_cap[i] = '0;
    end else begin
      n++;
      t_hist[n] = timer_in;
`ifdef CAPTURE_FILTER_EN
      md_all = 1'b1;
      for (int j = 1; j < FILTER_LEN; j++)
        if (rawlv(n - 1 - j) != rawlv(n - 1)) md_all = 1'b0;
      f_hist[n] = (md_all && rawlv(n - 1) != lv(n - 1)) ? rawlv(n - 1) : lv(n - 1);
`endif
      md_rise = lv(n - 1) && !lv(n - 2);
      md_fall = !lv(n - 1) && lv(n - 2);
      for (int i = 0; i < NUM_CAP; i++)
        md_ev[i] = (edge_sel[i][0] && md_rise) || (edge_sel[i][1] && md_fall);
      if (pw_mode) begin
        md_ev[0] = !m_high && md_rise;
        md_ev[1] = m_high && md_fall;
        if (md_ev[1]) m_pw = 8'((int'(counter_value) - int'(m_cap[0]) + 256) % 256);
      end
      for (int i = 0; i < NUM_CAP; i++) begin
        if (md_ev[i]) begin
          if (m_flag[i] && !flag_clr[i]) m_ovr[i] = 1'b1;
          else if (flag_clr[i])          m_ovr[i] = 1'b0;
          m_flag[i] = 1'b1;
          m_cap[i]  = counter_value;
        end else if (flag_clr[i]) begin
          m_flag[i] = 1'b0;
          m_ovr[i]  = 1'b0;
        end
      end
      if (!pw_mode)    m_high = 1'b0;
      else if (m_high) m_high = !md_fall;
      else             m_high = md_rise;
    end
  end

  // Drive counter for one clock and return at the following falling edge.
  task automatic step(input logic [7:0] c);
    counter_value = c;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    intr_en = '1;
    #1;
    vectors++; if (cap_value !== '0) begin miscompares++; $display("FAIL reset_cap got %h want 0", cap_value); end
    vectors++; if (pulse_width !== 8'h00) begin miscompares++; $display("FAIL reset_pw got %h want 0", pulse_width); end
    vectors++; if (flag !== '0) begin miscompares++; $display("FAIL reset_flag got %b want 0", flag); end
    vectors++; if (overrun !== '0) begin miscompares++; $display("FAIL reset_ovr got %b want 0", overrun); end
    vectors++; if (intr !== '0) begin miscompares++; $display("FAIL reset_intr got %b want 0", intr); end
    intr_en = '0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rising;
    edge_sel[0] = 2'b01;
    timer_in = 1'b1;
    repeat (LAT - 1) step(8'h11);
    vectors++; if (flag[0] !== 1'b0) begin miscompares++; $display("FAIL rise_early_flag got %b want 0", flag[0]); end
    step(8'h42);
    vectors++; if (cap_value[0] !== 8'h42) begin miscompares++; $display("FAIL rise_cap got %h want 42", cap_value[0]); end
    vectors++; if (flag[0] !== 1'b1) begin miscompares++; $display("FAIL rise_flag got %b want 1", flag[0]); end
    vectors++; if (intr[0] !== 1'b0) begin miscompares++; $display("FAIL rise_intr_masked got %b want 0", intr[0]); end
    intr_en[0] = 1'b1;
    #1;
    vectors++; if (intr[0] !== 1'b1) begin miscompares++; $display("FAIL rise_intr got %b want 1", intr[0]); end
    timer_in = 1'b0;
    repeat (LAT + 2) step(8'h99);
    vectors++; if (cap_value[0] !== 8'h42) begin miscompares++; $display("FAIL rise_fall_ignored got %h want 42", cap_value[0]); end
    flag_clr = 3'b001; step(8'h00); flag_clr = '0;
    vectors++; if (flag[0] !== 1'b0) begin miscompares++; $display("FAIL rise_clear got %b want 0", flag[0]); end
  endtask

  task automatic test_overrun;
    timer_in = 1'b1;
    repeat (LAT - 1) step(8'h00);
    step(8'h10);
    timer_in = 1'b0;
    repeat (LAT + 1) step(8'h00);
    timer_in = 1'b1;
    repeat (LAT - 1) step(8'h00);
    step(8'h30);
    vectors++; if (cap_value[0] !== 8'h30) begin miscompares++; $display("FAIL ovr_cap got %h want 30", cap_value[0]); end
    vectors++; if (overrun[0] !== 1'b1) begin miscompares++; $display("FAIL ovr_set got %b want 1", overrun[0]); end
    flag_clr = 3'b001; step(8'h00); flag_clr = '0;
    vectors++; if (flag[0] !== 1'b0) begin miscompares++; $display("FAIL ovr_clr_flag got %b want 0", flag[0]); end
    vectors++; if (overrun[0] !== 1'b0) begin miscompares++; $display("FAIL ovr_clr got %b want 0", overrun[0]); end
  endtask

  task automatic test_event_beats_clear;
    edge_sel[0] = 2'b00;
    edge_sel[1] = 2'b11;
    timer_in = 1'b0;
    repeat (LAT - 1) step(8'h00);
    step(8'h55);
    timer_in = 1'b1;
    repeat (LAT - 1) step(8'h00);
    step(8'h66);
    vectors++; if (overrun[1] !== 1'b1) begin miscompares++; $display("FAIL ebc_pre_ovr got %b want 1", overrun[1]); end
    timer_in = 1'b0;
    repeat (LAT - 1) step(8'h00);
    flag_clr = 3'b010; step(8'h77); flag_clr = '0;
    vectors++; if (flag[1] !== 1'b1) begin miscompares++; $display("FAIL ebc_flag got %b want 1", flag[1]); end
    vectors++; if (overrun[1] !== 1'b0) begin miscompares++; $display("FAIL ebc_ovr got %b want 0", overrun[1]); end
    vectors++; if (cap_value[1] !== 8'h77) begin miscompares++; $display("FAIL ebc_cap got %h want 77", cap_value[1]); end
  endtask

  task automatic test_pw_wrap;
    flag_clr = '1; step(8'h00); flag_clr = '0;
    pw_mode = 1'b1;
    timer_in = 1'b1;
    repeat (LAT - 1) step(8'hE0);
    step(8'hF0);
    vectors++; if (cap_value[0] !== 8'hF0) begin miscompares++; $display("FAIL pw_cap0 got %h want f0", cap_value[0]); end
    vectors++; if (cap_value[1] !== 8'h77) begin miscompares++; $display("FAIL pw_cap1_hold got %h want 77", cap_value[1]); end
    timer_in = 1'b0;
    repeat (LAT - 1) step(8'h00);
    step(8'h10);
    vectors++; if (cap_value[1] !== 8'h10) begin miscompares++; $display("FAIL pw_cap1 got %h want 10", cap_value[1]); end
    vectors++; if (pulse_width !== 8'h20) begin miscompares++; $display("FAIL pw_width got %h want 20", pulse_width); end
    vectors++; if (flag[1:0] !== 2'b11) begin miscompares++; $display("FAIL pw_flags got %b want 11", flag[1:0]); end
    pw_mode = 1'b0;
  endtask

`ifdef CAPTURE_FILTER_EN
  task automatic test_filter;
    edge_sel[0] = 2'b11;
    flag_clr = '1; step(8'h00); flag_clr = '0;
    timer_in = 1'b1; step(8'h00); step(8'h00);
    timer_in = 1'b0;
    repeat (12) step(8'h00);
    vectors++; if (flag[0] !== 1'b0) begin miscompares++; $display("FAIL filt_glitch got %b want 0", flag[0]); end
    for (int k = 1; k <= 5 + LAT; k++) begin
      timer_in = (k <= 5);
      step(8'(k));
      if (k == LAT - 1) begin
        vectors++; if (flag[0] !== 1'b0) begin miscompares++; $display("FAIL filt_early got %b want 0", flag[0]); end
      end
      if (k == LAT) begin
        vectors++; if (cap_value[0] !== 8'(LAT)) begin miscompares++; $display("FAIL filt_rise got %h want %h", cap_value[0], 8'(LAT)); end
      end
    end
    vectors++; if (cap_value[0] !== 8'(5 + LAT)) begin miscompares++; $display("FAIL filt_fall got %h want %h", cap_value[0], 8'(5 + LAT)); end
  endtask
`endif

  task automatic test_async_reset;
    #2 rst = 1'b1;
    #1;
    vectors++; if (cap_value !== '0) begin miscompares++; $display("FAIL areset_cap got %h want 0", cap_value); end
    vectors++; if (pulse_width !== 8'h00) begin miscompares++; $display("FAIL areset_pw got %h want 0", pulse_width); end
    vectors++; if ({flag, overrun, intr} !== '0) begin miscompares++; $display("FAIL areset_flags got %b want 0", {flag, overrun, intr}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random;
    logic [7:0] cnt = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) timer_in = ~timer_in;
      if ($urandom_range(0, 199) == 0) edge_sel = NUM_CAP*2'($urandom);
      if ($urandom_range(0, 149) == 0) pw_mode = ~pw_mode;
      if ($urandom_range(0, 49) == 0)  intr_en = NUM_CAP'($urandom);
      flag_clr = ($urandom_range(0, 9) == 0) ? NUM_CAP'($urandom) : '0;
      cnt = cnt + 8'(1 + $urandom_range(0, 2));
      if (c == 1500) begin
        #2 rst = 1'b1;
        #1;
        vectors++; if ({flag, overrun} !== '0) begin miscompares++; $display("FAIL rnd_reset got %b want 0", {flag, overrun}); end
        @(negedge clk);
        rst = 1'b0;
      end
      step(cnt);
      for (int i = 0; i < NUM_CAP; i++) begin
        vectors++;
        if (cap_value[i] !== m_cap[i]) begin
          miscompares++; $display("FAIL rnd_cap%0d cyc %0d got %h want %h", i, c, cap_value[i], m_cap[i]);
        end
      end
      vectors++; if (pulse_width !== m_pw) begin miscompares++; $display("FAIL rnd_pw cyc %0d got %h want %h", c, pulse_width, m_pw); end
      vectors++; if (flag !== m_flag) begin miscompares++; $display("FAIL rnd_flag cyc %0d got %b want %b", c, flag, m_flag); end
      vectors++; if (overrun !== m_ovr) begin miscompares++; $display("FAIL rnd_ovr cyc %0d got %b want %b", c, overrun, m_ovr); end
      vectors++; if (intr !== (intr_en & m_flag)) begin miscompares++; $display("FAIL rnd_intr cyc %0d got %b want %b", c, intr, intr_en & m_flag); end
    end
    flag_clr = '0;
  endtask

  initial begin
    test_reset();
    test_rising();
    test_overrun();
    test_event_beats_clear();
    test_pw_wrap();
`ifdef CAPTURE_FILTER_EN
    test_filter();
`endif
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/input_capture_block.md
Name: input_capture_block

Overview:
- Input-capture counterpart to the timer's compare/PWM output stage.
- Samples the external timer input and detects the selected edges.
- On each selected edge, latches the free-running 8-bit timer counter into per-channel capture registers and raises sticky flags, overrun indications and maskable interrupts.
- Optional pulse-width mode pairs channels 0/1 to measure high-pulse duration in timer ticks.

Parameters:
- NUM_CAP, 2, number of capture channels (must be >= 2 for pulse-width mode).
- SYNC_STAGES, 2, synchronizer flop depth on timer_in (>= 2).
- FILTER_LEN, 3, glitch-filter stability count in clocks (used only with CAPTURE_FILTER_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- timer_in  input  1  external asynchronous capture input.
- counter_value  input  8  current timer count.
- edge_sel  input  NUM_CAP x 2  per channel: 00 off, 01 rising, 10 falling, 11 both.
- intr_en  input  NUM_CAP  per-channel interrupt enable.
- flag_clr  input  NUM_CAP  single-cycle write-1-to-clear for flag/overrun.
- pw_mode  input  1  pulse-width measurement mode.
- cap_value  output  NUM_CAP x 8  captured counter values.
- pulse_width  output  8  last measured high-pulse width.
- flag  output  NUM_CAP  sticky capture flags.
- overrun  output  NUM_CAP  sticky overrun flags.
- intr  output  NUM_CAP  intr_en & flag (combinational).

Behaviour:
- Reset (async, rst=1): synchronizer, edge-detect register, cap_value, pulse_width, flag and overrun all clear to 0; pw FSM goes to PW_IDLE; intr=0.
- Input path: SYNC_STAGES-flop synchronizer -> sync_q. A one-flop delayed copy prev_q gives rise = sync_q & ~prev_q and fall = ~sync_q & prev_q.
- Latency: a capture event is registered at the (SYNC_STAGES+1)th rising clk edge after timer_in is first sampled at its new level. cap_value takes the counter_value present at that edge.
- Normal mode (pw_mode=0): event[i] = (edge_sel[i][0] & rise) | (edge_sel[i][1] & fall).
- On event[i]: cap_value[i] <= counter_value; flag[i] <= 1.
- Overrun: if flag[i] is already 1 and flag_clr[i]=0 in the same cycle, overrun[i] <= 1. The new value still overwrites cap_value[i] (newest wins).
- Clearing: flag_clr[i] clears flag[i] and overrun[i]. If event[i] and flag_clr[i] occur in the same cycle, the event wins: flag[i]=1, overrun[i]=0, cap_value updated.
- Pulse-width mode (pw_mode=1): edge_sel is ignored for channels 0 and 1. Channels >= 2 behave as in normal mode.
- PW FSM states:
  - PW_IDLE: on rise, cap_value[0] <= counter_value, flag[0] <= 1, go to PW_HIGH. Falls are ignored.
  - PW_HIGH: on fall, cap_value[1] <= counter_value, pulse_width <= (counter_value - cap_value[0]) mod 256, flag[1] <= 1, go to PW_IDLE. Rise cannot occur here (single-bit input).
- Overrun rules apply to flag[0] and flag[1] in pulse-width mode exactly as in normal mode.
- Width arithmetic is 8-bit modulo: a pulse of exactly 256 ticks reads 0; longer pulses alias. Both are accepted limitations.
- pw_mode deasserted in any state forces PW_IDLE on the next clock; cap_value, pulse_width and flags are retained.
- pw_mode asserted while timer_in is already high: the FSM waits for the next rise, so no partial measurement is produced.
- rst asserted mid-pulse: everything returns to reset values. A fall seen after reset release is ignored because the FSM is in PW_IDLE.

Optional Feature:
- Macro: CAPTURE_FILTER_EN.
- When defined: a digital glitch filter sits between sync_q and the edge detector. The filtered level changes only after sync_q has held a new value for FILTER_LEN consecutive clocks, and shorter pulses are discarded. Latency grows by FILTER_LEN clocks. Filter counter and filtered level reset to 0.
- When undefined: no filter, FILTER_LEN is unused, and latency is SYNC_STAGES+1.

Test Plan:
- Reset check: assert rst mid-run -> all outputs 0 immediately (asynchronous), with no clk edge needed.
- Rising capture: edge_sel[0]=01, counter_value=0x42 at the capture edge, timer_in 0->1 -> at cycle SYNC_STAGES+1, cap_value[0]=0x42, flag[0]=1; intr[0]=1 only when intr_en[0]=1.
- Overrun: two rising edges captured at 0x10 and 0x30 with no clear -> cap_value[0]=0x30, overrun[0]=1. Then flag_clr[0] -> flag[0]=0, overrun[0]=0.
- Event beats clear: edge_sel[1]=11, pulse flag_clr[1] on the same cycle as a fall event -> flag[1]=1, overrun[1]=0, cap_value[1] updated.
- Pulse width with wrap: pw_mode=1, rise captured at 0xF0, fall captured at 0x10 -> cap_value[0]=0xF0, cap_value[1]=0x10, pulse_width=0x20, flag[0]=flag[1]=1.
- Filter (CAPTURE_FILTER_EN, FILTER_LEN=3): a 2-clock high glitch gives no event. A 5-clock high pulse with edge_sel[0]=11 gives a rise capture and then a fall capture, each FILTER_LEN clocks later than in the unfiltered build.
